// File: rtl/spi_pkg.sv
// Shared definitions for the bus-attached SPI master: register offsets,
// control bit positions, transfer lengths and FSM states.
// Optional feature macro: SPI_FAST_EN (32-bit fast transfers).
package spi_pkg;

  localparam int unsigned REG_DATA   = 0;
  localparam int unsigned REG_CTRL   = 1;

  localparam int unsigned CTRL_SEL0  = 0;
  localparam int unsigned CTRL_SEL1  = 1;
  localparam int unsigned CTRL_FAST  = 2;
  localparam int unsigned CTRL_NETEN = 3;

  localparam int unsigned LEN_SLOW   = 8;
  localparam int unsigned LEN_FAST   = 32;

`ifdef SPI_FAST_EN
  localparam int unsigned SHREG_W    = LEN_FAST;
`else
  localparam int unsigned SHREG_W    = LEN_SLOW;
`endif

  localparam int unsigned BITCNT_W   = $clog2(SHREG_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_baud.sv
// Half-period divider for SCLK: counts 0..i_div while running and emits a
// one-cycle tick on the terminal count. i_clear restarts the count.
module spi_baud #(
  parameter int unsigned DIV_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_clear,
  input  logic             i_run,
  output logic             o_tick_c
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick_c = i_run && (r_cnt == i_div);

  // Divider counter; wraps on the tick, held at zero when idle or cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_run || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi.sv
// SPI master (mode 0, MSB first) on two I/O words: data and control/status.
// Slow mode: 8 bits at SLOW_DIV. With SPI_FAST_EN defined, control bit 2
// selects 32-bit transfers at FAST_DIV; otherwise every transfer is slow.
module spi
  import spi_pkg::*;
#(
  parameter int unsigned SLOW_DIV = 63,
  parameter int unsigned FAST_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [1:0]  spi_ss_n,
  output logic        net_en
);

  localparam int unsigned DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int unsigned DIV_W   = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);

  spi_state_e            r_state;
  spi_state_e            w_next;
  logic [1:0]            r_sel;
  logic                  r_net_en;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_miso_meta;
  logic                  r_miso_sync;
  logic [SHREG_W-1:0]    r_shreg;
  logic [BITCNT_W-1:0]   r_bitcnt;

  logic                  w_start;
  logic                  w_ctrl_wr;
  logic                  w_tick;
  logic                  w_clear;
  logic                  w_busy;
  logic                  w_last;
  logic                  w_msb;
  logic                  w_load_msb;
  logic [SHREG_W-1:0]    w_load;
  logic [BITCNT_W-1:0]   w_len;
  logic [DIV_W-1:0]      w_div;
  logic [31:0]           w_data_rd;

  assign w_start   = stb && we && (addr == 1'(REG_DATA)) && (r_state == ST_IDLE);
  assign w_ctrl_wr = stb && we && (addr == 1'(REG_CTRL));
  assign w_busy    = (r_state != ST_IDLE);
  assign w_clear   = (w_next != r_state);
  assign w_last    = (r_bitcnt == BITCNT_W'(1));

`ifdef SPI_FAST_EN
  logic r_fast_cfg;
  logic r_fast;

  // Fast request from control; the transfer mode is captured only at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fast_cfg <= 1'b0;
      r_fast     <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_fast_cfg <= data_in[CTRL_FAST];
      if (w_start)   r_fast     <= r_fast_cfg;
    end
  end

  assign w_load     = r_fast_cfg ? data_in : {24'b0, data_in[7:0]};
  assign w_load_msb = r_fast_cfg ? data_in[31] : data_in[7];
  assign w_len      = r_fast_cfg ? BITCNT_W'(LEN_FAST) : BITCNT_W'(LEN_SLOW);
  assign w_msb      = r_fast ? r_shreg[31] : r_shreg[7];
  assign w_div      = r_fast ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);
  assign w_data_rd  = r_fast ? r_shreg : {24'b0, r_shreg[7:0]};
`else
  logic w_unused_bits;

  assign w_load        = data_in[7:0];
  assign w_load_msb    = data_in[7];
  assign w_len         = BITCNT_W'(LEN_SLOW);
  assign w_msb         = r_shreg[7];
  assign w_div         = DIV_W'(SLOW_DIV);
  assign w_data_rd     = {24'b0, r_shreg};
  assign w_unused_bits = ^data_in[31:8];
`endif

  spi_baud #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_div    (w_div),
    .i_clear  (w_clear),
    .i_run    (w_busy),
    .o_tick_c (w_tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: each SCLK phase lasts one divider period.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_LOW;
      ST_LOW:  if (w_tick)  w_next = ST_HIGH;
      ST_HIGH: if (w_tick)  w_next = w_last ? ST_IDLE : ST_LOW;
      default: w_next = ST_IDLE;
    endcase
  end

  // Shift datapath: sample MISO on the rising phase, present MOSI on falling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b1;
    end else begin
      r_sclk <= (w_next == ST_HIGH);
      if (w_start) begin
        r_shreg  <= w_load;
        r_bitcnt <= w_len;
        r_mosi   <= w_load_msb;
      end else if ((r_state == ST_LOW) && w_tick) begin
        r_shreg <= {r_shreg[SHREG_W-2:0], r_miso_sync};
      end else if ((r_state == ST_HIGH) && w_tick) begin
        r_bitcnt <= r_bitcnt - BITCNT_W'(1);
        r_mosi   <= w_last ? 1'b1 : w_msb;
      end
    end
  end

  // Slave selects and network enable follow control writes at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= 2'b00;
      r_net_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_sel    <= {data_in[CTRL_SEL1], data_in[CTRL_SEL0]};
      r_net_en <= data_in[CTRL_NETEN];
    end
  end

  // Two-flop MISO synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_miso_meta <= spi_miso;
      r_miso_sync <= r_miso_meta;
    end
  end

  assign ack      = stb;
  assign data_out = (addr == 1'(REG_CTRL)) ? {31'b0, ~w_busy} : w_data_rd;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_ss_n = ~r_sel;
  assign net_en   = r_net_en;

endmodule

// File: tb/tb_spi.sv
// Scoreboard bench for spi: bus reads and MOSI bits are queued when issued
// and checked by a negedge monitor; a MISO model or loopback feeds the DUT.
module tb_spi;

`ifdef SPI_FAST_EN
  localparam int          FAST_N    = 32;
  localparam int          FAST_PER  = 4;
  localparam logic [31:0] FAST_MOSI = 32'hDEADBEEF;
  localparam logic [31:0] FAST_RES  = 32'h12345678;
`else
  localparam int          FAST_N    = 8;
  localparam int          FAST_PER  = 128;
  localparam logic [31:0] FAST_MOSI = 32'h000000EF;
  localparam logic [31:0] FAST_RES  = 32'h00000012;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [1:0]  spi_ss_n;
  logic        net_en;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  logic        bit_q[$];

  logic        prev_sclk = 1'b0;
  int          last_rise = -1;
  int          rise_cnt  = 0;
  int          exp_per   = 0;
  bit          chk_bits  = 1'b0;
  bit          loopback  = 1'b0;
  logic [31:0] miso_word = '0;
  int          miso_idx  = 0;
  logic        miso_drv  = 1'b1;

  assign spi_miso = loopback ? spi_mosi : miso_drv;

  spi dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n),
    .net_en   (net_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: bus reads against the read queue, SCLK rises against the bit queue.
  always @(negedge clk) begin
    logic [31:0] e;
    string       n;
    if (stb && !we) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %h expected none", data_out);
      end else begin
        e = rd_q.pop_front();
        n = rd_name_q.pop_front();
        check(n, data_out, e);
        check({n, "_ack"}, 32'(ack), 32'h1);
      end
    end
    if (rst_n && spi_sclk && !prev_sclk) begin
      rise_cnt++;
      if (chk_bits) begin
        if (last_rise >= 0) check("sclk_period", 32'(cyc - last_rise), 32'(exp_per));
        if (bit_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_sclk: got rise %0d expected none", rise_cnt);
        end else begin
          check("mosi_bit", 32'(spi_mosi), 32'(bit_q.pop_front()));
        end
      end
      last_rise = cyc;
      if (miso_idx > 0) begin
        miso_idx--;
        miso_drv = miso_word[miso_idx];
      end
    end
    prev_sclk = spi_sclk;
  end

  task automatic bus_wr(input logic a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic a, input logic [31:0] e, input string n);
    rd_q.push_back(e);
    rd_name_q.push_back(n);
    stb = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic arm(input logic [31:0] word, input int nbits, input int per, input bit lb);
    bit_q.delete();
    for (int i = nbits - 1; i >= 0; i--) bit_q.push_back(word[i]);
    rise_cnt  = 0;
    last_rise = -1;
    exp_per   = per;
    chk_bits  = 1'b1;
    loopback  = lb;
  endtask

  task automatic end_xfer(input string n, input int nbits);
    check({n, "_rises"}, 32'(rise_cnt), 32'(nbits));
    check({n, "_bits_left"}, 32'(bit_q.size()), 32'h0);
  endtask

  task automatic check_reset_pins(input string n);
    check({n, "_sclk"}, 32'(spi_sclk), 32'h0);
    check({n, "_mosi"}, 32'(spi_mosi), 32'h1);
    check({n, "_ss_n"}, 32'(spi_ss_n), 32'h3);
    check({n, "_net_en"}, 32'(net_en), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("reset");
    rst_n = 1'b1;
    idle(2);
    bus_rd(1'b1, 32'h1, "reset_rdy");
    bus_rd(1'b0, 32'h0, "reset_data");

    // Reset in the middle of a slow loopback transfer of 0x5A.
    bus_wr(1'b1, 32'h1);
    check("sel0_ss_n", 32'(spi_ss_n), 32'h2);
    chk_bits = 1'b0; loopback = 1'b1; rise_cnt = 0;
    bus_wr(1'b0, 32'h5A);
    idle(330);
    bus_rd(1'b0, 32'hD2, "partial_read");
    check("pre_rst_rises", 32'(rise_cnt), 32'h3);
    check("pre_rst_sclk", 32'(spi_sclk), 32'h1);
    check("pre_rst_mosi", 32'(spi_mosi), 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_pins("mid_rst");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    bus_rd(1'b1, 32'h1, "post_rst_rdy");
    bus_rd(1'b0, 32'h0, "post_rst_data");

    // Slow loopback of 0xA5.
    bus_wr(1'b1, 32'h1);
    arm(32'hA5, 8, 128, 1'b1);
    bus_wr(1'b0, 32'hA5);
    idle(1023);
    bus_rd(1'b1, 32'h0, "slow_busy");
    bus_rd(1'b1, 32'h1, "slow_rdy");
    bus_rd(1'b0, 32'hA5, "slow_data");
    end_xfer("slow", 8);

    // Data write while busy is ignored.
    arm(32'hA5, 8, 128, 1'b1);
    bus_wr(1'b0, 32'hA5);
    idle(4);
    bus_wr(1'b0, 32'h33);
    idle(1018);
    bus_rd(1'b1, 32'h0, "ign_busy");
    bus_rd(1'b1, 32'h1, "ign_rdy");
    bus_rd(1'b0, 32'hA5, "ign_data");
    end_xfer("ign", 8);

    // Control write mid-transfer changes selects/net_en only.
    arm(32'hC3, 8, 128, 1'b1);
    bus_wr(1'b0, 32'hC3);
    idle(9);
    bus_wr(1'b1, 32'hA);
    check("ctrl_mid_ss_n", 32'(spi_ss_n), 32'h1);
    check("ctrl_mid_net_en", 32'(net_en), 32'h1);
    idle(489);
    bus_rd(1'b1, 32'h0, "ctrl_mid_status");
    idle(523);
    bus_rd(1'b1, 32'h0, "ctrl_busy");
    bus_rd(1'b1, 32'h1, "ctrl_rdy");
    bus_rd(1'b0, 32'hC3, "ctrl_data");
    end_xfer("ctrl", 8);

    // Fast request with MISO model streaming 0x12345678; slow rewrite mid-way.
    loopback  = 1'b0;
    miso_word = 32'h12345678;
    miso_idx  = 31;
    miso_drv  = miso_word[31];
    bus_wr(1'b1, 32'h5);
    check("fast_ss_n", 32'(spi_ss_n), 32'h2);
    check("fast_net_en", 32'(net_en), 32'h0);
    arm(FAST_MOSI, FAST_N, FAST_PER, 1'b0);
    bus_wr(1'b0, 32'hDEADBEEF);
    idle(9);
    bus_wr(1'b1, 32'h1);
    idle(FAST_N * FAST_PER - 11);
    bus_rd(1'b1, 32'h0, "fast_busy");
    bus_rd(1'b1, 32'h1, "fast_rdy");
    bus_rd(1'b0, FAST_RES, "fast_data");
    end_xfer("fast", FAST_N);

    idle(2);
    check("rd_queue_empty", 32'(rd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
